// File: rtl/dm_sbus_responder_if.sv
// Request/grant/response bundle between an SBA initiator and the
// system-bus responder. Signal names follow the responder's port list.
interface dm_sbus_responder_if #(
  parameter int BusWidth = 32
);
  logic                    req_i;
  logic [BusWidth-1:0]     add_i;
  logic                    we_i;
  logic [BusWidth-1:0]     wdata_i;
  logic [BusWidth/8-1:0]   be_i;
  logic                    stall_i;
  logic                    err_inject_i;
  logic                    gnt_o;
  logic                    r_valid_o;
  logic                    r_err_o;
  logic                    r_other_err_o;
  logic [BusWidth-1:0]     r_rdata_o;
  logic                    busy_o;

  modport master (
    output req_i, add_i, we_i, wdata_i, be_i, stall_i, err_inject_i,
    input  gnt_o, r_valid_o, r_err_o, r_other_err_o, r_rdata_o, busy_o
  );

  modport slave (
    input  req_i, add_i, we_i, wdata_i, be_i, stall_i, err_inject_i,
    output gnt_o, r_valid_o, r_err_o, r_other_err_o, r_rdata_o, busy_o
  );
endinterface

// File: rtl/dm_sbus_responder.sv
// System-bus memory target for the debug module's SBA initiator.
// One outstanding request at a time: req/gnt handshake with a programmable
// grant latency and stall, then a single r_valid pulse RespDelay cycles
// after the grant. Backed by a word-addressed register memory that is
// cleared by reset.
module dm_sbus_responder #(
  parameter int                   BusWidth  = 32,
  parameter int                   MemWords  = 256,
  parameter logic [BusWidth-1:0]  BaseAddr  = BusWidth'(32'h8000_0000),
  parameter int                   GntDelay  = 0,
  parameter int                   RespDelay = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dm_sbus_responder_if.slave  bus
);

  localparam int ByteCnt = BusWidth / 8;
  localparam int OffW    = $clog2(ByteCnt);
  localparam int IdxW    = $clog2(MemWords);

  // The IDLE request cycle already counts as the first wait cycle, so the
  // wait counter starts one below GntDelay; this makes the first request
  // cycle t grant at t+GntDelay when nothing stalls.
  localparam logic [3:0] GntLoad  = (GntDelay == 0) ? 4'd0 : 4'(GntDelay - 1);
  localparam logic [3:0] RespLoad = 4'(RespDelay - 1);
  localparam logic       GntNow   = (GntDelay == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state, state_nxt;
  logic [3:0]          wait_cnt, wait_cnt_nxt;
  logic [3:0]          resp_cnt, resp_cnt_nxt;
  logic                gnt;
  logic                resp_fire;

  logic [BusWidth-1:0] mem [MemWords];
  logic [BusWidth-1:0] offset;
  logic [BusWidth-1:0] word_sel;
  logic [IdxW-1:0]     idx;
  logic                in_range;

  logic                oor_q;
  logic                inj_q;
  logic [BusWidth-1:0] rdata_cap;
  logic [BusWidth-1:0] rdata_hold;

  // Address decode: unsigned full-width compare, no wrap below BaseAddr.
  always_comb begin
    offset   = bus.add_i - BaseAddr;
    word_sel = offset >> OffW;
    in_range = (bus.add_i >= BaseAddr) && ((word_sel >> IdxW) == '0);
    idx      = word_sel[IdxW-1:0];
  end

  // Next-state logic, grant and response strobe.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    resp_cnt_nxt = resp_cnt;
    gnt          = 1'b0;
    resp_fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_i) begin
          if (GntNow && !bus.stall_i) begin
            gnt          = 1'b1;
            state_nxt    = RESP;
            resp_cnt_nxt = RespLoad;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = GntLoad;
          end
        end
      end
      WAIT: begin
        if (!bus.req_i) begin
          state_nxt = IDLE;
        end else if ((wait_cnt == 4'd0) && !bus.stall_i) begin
          gnt          = 1'b1;
          state_nxt    = RESP;
          resp_cnt_nxt = RespLoad;
        end else if (wait_cnt != 4'd0) begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_cnt == 4'd0) begin
          resp_fire = 1'b1;
          state_nxt = IDLE;
        end else begin
          resp_cnt_nxt = resp_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      resp_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      resp_cnt <= resp_cnt_nxt;
    end
  end

  // Memory: byte-enabled write on the grant edge of a clean in-range write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MemWords; i++) begin
        mem[i] <= '0;
      end
    end else if (gnt && bus.we_i && in_range && !bus.err_inject_i) begin
      for (int b = 0; b < ByteCnt; b++) begin
        if (bus.be_i[b]) begin
          mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Grant-edge capture of the response fields; read data is zero for
  // writes, out-of-range and injected accesses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oor_q     <= 1'b0;
      inj_q     <= 1'b0;
      rdata_cap <= '0;
    end else if (gnt) begin
      oor_q     <= !in_range;
      inj_q     <= bus.err_inject_i;
      rdata_cap <= (in_range && !bus.err_inject_i && !bus.we_i) ? mem[idx] : '0;
    end
  end

  // Keeps the last delivered read data on the bus between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_hold <= '0;
    end else if (resp_fire) begin
      rdata_hold <= rdata_cap;
    end
  end

  assign bus.gnt_o         = gnt;
  assign bus.r_valid_o     = resp_fire;
  assign bus.r_err_o       = resp_fire && oor_q;
  assign bus.r_other_err_o = resp_fire && inj_q && !oor_q;
  assign bus.r_rdata_o     = resp_fire ? rdata_cap : rdata_hold;
  assign bus.busy_o        = (state != IDLE);

endmodule

// File: tb/tb_dm_sbus_responder.sv
// Bench for dm_sbus_responder: three instances with different grant and
// response latencies share one stimulus set; a select picks the active one.
module tb_dm_sbus_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req, we, stall, inj;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  int          sel;
  logic        gnt, r_valid, r_err, r_oth, busy;
  logic [31:0] rdata;

  dm_sbus_responder_if #(.BusWidth(32)) bus0 ();
  dm_sbus_responder_if #(.BusWidth(32)) bus1 ();
  dm_sbus_responder_if #(.BusWidth(32)) bus2 ();

  assign bus0.req_i = req && (sel == 0);
  assign bus1.req_i = req && (sel == 1);
  assign bus2.req_i = req && (sel == 2);
  assign bus0.add_i = add;   assign bus1.add_i = add;   assign bus2.add_i = add;
  assign bus0.we_i = we;     assign bus1.we_i = we;     assign bus2.we_i = we;
  assign bus0.wdata_i = wdata; assign bus1.wdata_i = wdata; assign bus2.wdata_i = wdata;
  assign bus0.be_i = be;     assign bus1.be_i = be;     assign bus2.be_i = be;
  assign bus0.stall_i = stall; assign bus1.stall_i = stall; assign bus2.stall_i = stall;
  assign bus0.err_inject_i = inj; assign bus1.err_inject_i = inj; assign bus2.err_inject_i = inj;

  assign gnt     = (sel == 0) ? bus0.gnt_o         : (sel == 1) ? bus1.gnt_o         : bus2.gnt_o;
  assign r_valid = (sel == 0) ? bus0.r_valid_o     : (sel == 1) ? bus1.r_valid_o     : bus2.r_valid_o;
  assign r_err   = (sel == 0) ? bus0.r_err_o       : (sel == 1) ? bus1.r_err_o       : bus2.r_err_o;
  assign r_oth   = (sel == 0) ? bus0.r_other_err_o : (sel == 1) ? bus1.r_other_err_o : bus2.r_other_err_o;
  assign rdata   = (sel == 0) ? bus0.r_rdata_o     : (sel == 1) ? bus1.r_rdata_o     : bus2.r_rdata_o;
  assign busy    = (sel == 0) ? bus0.busy_o        : (sel == 1) ? bus1.busy_o        : bus2.busy_o;

  dm_sbus_responder #(.BusWidth(32), .MemWords(WORDS), .BaseAddr(BASE), .GntDelay(0), .RespDelay(1))
    dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  dm_sbus_responder #(.BusWidth(32), .MemWords(WORDS), .BaseAddr(BASE), .GntDelay(2), .RespDelay(3))
    dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
  dm_sbus_responder #(.BusWidth(32), .MemWords(WORDS), .BaseAddr(BASE), .GntDelay(3), .RespDelay(2))
    dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mmem [WORDS];
  int cur_g, cur_r;

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) mmem[i] = 32'h0;
  endtask

  // Grant = first cycle at or after GntDelay that is not stalled;
  // response = grant + RespDelay; memory updated per byte lane.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, input logic i, input logic [15:0] stl,
                              output int eg, output int erv, output logic eerr,
                              output logic eoth, output logic [31:0] edat);
    int k;
    int unsigned word;
    k = cur_g;
    while (k < 16 && stl[k]) k++;
    eg   = k;
    erv  = k + cur_r;
    eerr = (a < BASE) || (((a - BASE) / 4) >= 32'(WORDS));
    eoth = i && !eerr;
    edat = 32'h0;
    if (!eerr && !i) begin
      word = (a - BASE) / 4;
      if (w) begin
        for (int n = 0; n < 4; n++)
          if (b[n]) mmem[word][8*n +: 8] = d[8*n +: 8];
      end else begin
        edat = mmem[word];
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset();
    req = 0; stall = 0; inj = 0; we = 0; add = 0; wdata = 0; be = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic i, input logic [15:0] stl,
                         output int g_at, output int rv_at, output int g_abs,
                         output logic o_err, output logic o_oth, output logic [31:0] o_dat,
                         output int stray);
    int k;
    g_at = -1; rv_at = -1; g_abs = -1; o_err = 0; o_oth = 0; o_dat = 0; stray = 0;
    req = 1; we = w; add = a; wdata = d; be = b; inj = i; k = 0;
    while (g_at < 0 && k < 40) begin
      stall = (k < 16) ? stl[k] : 1'b0;
      @(negedge clk);
      if (r_valid || r_err || r_oth) stray++;
      if (gnt) begin g_at = k; g_abs = cyc; end
      @(posedge clk); #1; k++;
    end
    req = 0; stall = 0; inj = 0;
    we = 1'($urandom); add = $urandom; wdata = $urandom; be = 4'($urandom);
    while (rv_at < 0 && k < 80) begin
      @(negedge clk);
      if (gnt) stray++;
      if (r_valid) begin
        rv_at = k; o_err = r_err; o_oth = r_oth; o_dat = rdata;
      end else if (r_err || r_oth) begin
        stray++;
      end
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic do_and_check(input string tag, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b, input logic i,
                              input logic [15:0] stl);
    int eg, erv, gg, rv, gabs, stray;
    logic eerr, eoth, oerr, ooth;
    logic [31:0] edat, odat;
    model_access(w, a, d, b, i, stl, eg, erv, eerr, eoth, edat);
    run_txn(w, a, d, b, i, stl, gg, rv, gabs, oerr, ooth, odat, stray);
    check({tag, " gnt_cycle"}, gg, eg);
    check({tag, " rvalid_cycle"}, rv, erv);
    check({tag, " r_err"}, {31'b0, oerr}, {31'b0, eerr});
    check({tag, " r_other_err"}, {31'b0, ooth}, {31'b0, eoth});
    check({tag, " r_rdata"}, odat, edat);
    check({tag, " stray_strobes"}, stray, 0);
  endtask

  task automatic rand_txns(input string tag, input int n);
    logic [31:0] a;
    int r;
    for (int t = 0; t < n; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE - 32'($urandom_range(1, 64));
      else if (r == 1) a = BASE + 32'h400 + 32'($urandom_range(0, 255));
      else             a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      do_and_check(tag, 1'($urandom), a, $urandom, 4'($urandom),
                   ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'hFF) : 16'h0);
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic        i;
    logic [15:0] stl;
    int          eg;
    int          erv;
    logic        eerr;
    logic        eoth;
    logic [31:0] edat;
  } vec_t;

  vec_t tbl [13];

  initial begin : main
    int gg, rv, ga1, ga2, stray, k, gk, nrv, ngnt;
    logic oerr, ooth, b1, b2;
    logic [31:0] odat, dummy_d;
    logic [9:0] busy_v, gnt_v, rv_v;
    int eg, erv;
    logic eerr, eoth;

    tbl[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 16'h0,    0, 1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'hF, 1'b0, 16'h0,    0, 1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 1'b0, 16'h0,    0, 1, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'hF, 1'b0, 16'h0,    0, 1, 1'b0, 1'b0, 32'hDE22_BE44};
    tbl[4]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'hF, 1'b0, 16'h0,    0, 1, 1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'h8000_0400, 32'hFFFF_FFFF, 4'hF, 1'b0, 16'h0,    0, 1, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h8000_0010, 32'h0,         4'hF, 1'b1, 16'h0,    0, 1, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'h8000_0014, 32'h5555_5555, 4'hF, 1'b1, 16'h0,    0, 1, 1'b0, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 32'h8000_0014, 32'h0,         4'hF, 1'b0, 16'h0,    0, 1, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h8000_03FC, 32'h0,         4'hF, 1'b0, 16'h0,    0, 1, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 32'h8000_0010, 32'h0,         4'hF, 1'b0, 16'h0003, 2, 3, 1'b0, 1'b0, 32'hDE22_BE44};
    tbl[11] = '{1'b0, 32'h8000_0013, 32'h0,         4'hF, 1'b0, 16'h0,    0, 1, 1'b0, 1'b0, 32'hDE22_BE44};
    tbl[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 1'b1, 16'h0,    0, 1, 1'b1, 1'b0, 32'h0};

    // ---- instance 0: GntDelay 0, RespDelay 1 ----
    sel = 0; cur_g = 0; cur_r = 1;
    req = 0; stall = 0; inj = 0; we = 0; add = 0; wdata = 0; be = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset gnt", {31'b0, gnt}, 0);
    check("reset r_valid", {31'b0, r_valid}, 0);
    check("reset r_err", {31'b0, r_err}, 0);
    check("reset r_other_err", {31'b0, r_oth}, 0);
    check("reset r_rdata", rdata, 0);
    check("reset busy", {31'b0, busy}, 0);
    apply_reset();

    for (int v = 0; v < 13; v++) begin
      model_access(tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].b, tbl[v].i, tbl[v].stl,
                   eg, erv, eerr, eoth, dummy_d);
      run_txn(tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].b, tbl[v].i, tbl[v].stl,
              gg, rv, ga1, oerr, ooth, odat, stray);
      check($sformatf("vec%0d gnt_cycle", v), gg, tbl[v].eg);
      check($sformatf("vec%0d rvalid_cycle", v), rv, tbl[v].erv);
      check($sformatf("vec%0d r_err", v), {31'b0, oerr}, {31'b0, tbl[v].eerr});
      check($sformatf("vec%0d r_other_err", v), {31'b0, ooth}, {31'b0, tbl[v].eoth});
      check($sformatf("vec%0d r_rdata", v), odat, tbl[v].edat);
      check($sformatf("vec%0d stray", v), stray, 0);
    end

    for (int wd = 0; wd < WORDS; wd++)
      do_and_check("memscan", 1'b0, BASE + 32'(wd * 4), 32'h0, 4'hF, 1'b0, 16'h0);

    run_txn(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, 16'h0, gg, rv, ga1, oerr, ooth, odat, stray);
    run_txn(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, 16'h0, gg, rv, ga2, oerr, ooth, odat, stray);
    check("b2b grant spacing", ga2 - ga1, 2);
    check("b2b second rvalid", rv, 1);
    check("b2b second rdata", odat, 32'hDE22_BE44);

    rand_txns("rand_g0r1", 200);

    // ---- instance 1: GntDelay 2, RespDelay 3 ----
    sel = 1; cur_g = 2; cur_r = 3;
    apply_reset();
    req = 1; we = 0; add = BASE + 32'h8; be = 4'hF; busy_v = '0; gnt_v = '0; rv_v = '0;
    for (int c = 0; c < 10; c++) begin
      stall = (c >= 1 && c <= 3);
      @(negedge clk);
      busy_v[c] = busy; gnt_v[c] = gnt; rv_v[c] = r_valid;
      @(posedge clk); #1;
      if (gnt_v[c]) req = 0;
    end
    req = 0; stall = 0;
    check("stall gnt pattern", {22'b0, gnt_v}, 32'h010);
    check("stall rvalid pattern", {22'b0, rv_v}, 32'h080);
    check("stall busy pattern", {22'b0, busy_v}, 32'h0FE);

    rand_txns("rand_g2r3", 100);

    do_and_check("pre_rst write", 1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, 16'h0);
    do_and_check("pre_rst read", 1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, 16'h0);
    req = 1; we = 0; add = BASE + 32'h20; be = 4'hF; k = 0; gk = -1;
    while (gk < 0 && k < 20) begin
      @(negedge clk);
      if (gnt) gk = k;
      @(posedge clk); #1; k++;
    end
    req = 0;
    check("rst read gnt_cycle", gk, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst gnt", {31'b0, gnt}, 0);
    check("midrst r_valid", {31'b0, r_valid}, 0);
    check("midrst r_err", {31'b0, r_err}, 0);
    check("midrst r_other_err", {31'b0, r_oth}, 0);
    check("midrst r_rdata", rdata, 0);
    check("midrst busy", {31'b0, busy}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    nrv = 0;
    repeat (8) begin
      @(negedge clk);
      if (r_valid) nrv++;
      @(posedge clk); #1;
    end
    check("dropped response count", nrv, 0);
    do_and_check("post_rst read", 1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, 16'h0);
    do_and_check("post_rst read2", 1'b0, BASE + 32'(4 * $urandom_range(0, WORDS - 1)),
                 32'h0, 4'hF, 1'b0, 16'h0);

    // ---- instance 2: GntDelay 3, RespDelay 2 ----
    sel = 2; cur_g = 3; cur_r = 2;
    apply_reset();
    req = 1; we = 0; add = BASE; be = 4'hF; ngnt = 0; nrv = 0; b1 = 0; b2 = 1;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) req = 0;
      @(negedge clk);
      if (gnt) ngnt++;
      if (r_valid) nrv++;
      if (c == 1) b1 = busy;
      if (c == 2) b2 = busy;
      @(posedge clk); #1;
    end
    check("abort gnt count", ngnt, 0);
    check("abort rvalid count", nrv, 0);
    check("abort busy while waiting", {31'b0, b1}, 1);
    check("abort busy after drop", {31'b0, b2}, 0);

    do_and_check("g3 write", 1'b1, BASE + 32'h3FC, 32'h0BAD_F00D, 4'hF, 1'b0, 16'h0);
    do_and_check("g3 read", 1'b0, BASE + 32'h3FC, 32'h0, 4'hF, 1'b0, 16'h0);
    rand_txns("rand_g3r2", 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
